iseq_fifo_reader: RTL and testbench

ISEQ_FIFO_READER -- requirements
Module: iseq_fifo_reader

---
 rtl/iseq_fifo_reader_pkg.sv | 21 ++
 rtl/iseq_fifo_reader.sv | 133 +++++++++++++
 tb/tb_iseq_fifo_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iseq_fifo_reader_pkg.sv
// Shared definitions for the instruction-sequence FIFO reader: opcode field
// position, the END_ISEQ terminator opcode and the reader state encoding.
package iseq_fifo_reader_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 28;

  localparam logic [3:0] END_ISEQ = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic is_end_iseq(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO] == END_ISEQ;
  endfunction

endpackage

// File: rtl/iseq_fifo_reader.sv
// Reads an instruction sequence alternately from two FWFT FIFOs and hands the
// words to the command issue stage. Define ISEQ_CNT_EN to get the dispatch counter.
module iseq_fifo_reader
  import iseq_fifo_reader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             process_iseq,
  input  logic             instr0_fifo_empty,
  input  logic             instr1_fifo_empty,
  input  logic [31:0]      instr0_fifo_data,
  input  logic [31:0]      instr1_fifo_data,
  output logic             instr0_fifo_rd_en,
  output logic             instr1_fifo_rd_en,
  output logic             dispatcher_ready,
  output logic             instr_valid,
  output logic [31:0]      instr_data,
  input  logic             instr_ack,
  output logic             seq_err,
  output logic [CNT_W-1:0] iseq_cnt
);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  logic        out_free;
  logic        head_empty;
  logic [31:0] head_data;
  logic        head_is_end;
  logic        pop;
  logic        start_seq;
  logic        end_seq;

  // The output register can take a new word if it is empty or being acked now.
  assign out_free    = !valid_q || instr_ack;
  assign head_empty  = sel_q ? instr1_fifo_empty : instr0_fifo_empty;
  assign head_data   = sel_q ? instr1_fifo_data  : instr0_fifo_data;
  assign head_is_end = is_end_iseq(head_data);
  assign start_seq   = (state_q == ST_IDLE)  && (state_d == ST_RUN);
  assign end_seq     = (state_q == ST_DRAIN) && (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (process_iseq) state_d = ST_RUN;
      ST_RUN: begin
        if (head_empty)                   state_d = ST_DRAIN;
        else if (out_free && head_is_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (out_free) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pop strobes are gated by reset so an aborted sequence never pops again.
  always_comb begin
    pop               = rst && (state_q == ST_RUN) && !head_empty && out_free;
    instr0_fifo_rd_en = pop && !sel_q;
    instr1_fifo_rd_en = pop && sel_q;
  end

  always_comb begin
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    ready_d = (state_d == ST_IDLE);
    if (start_seq)  sel_d = 1'b0;
    else if (pop)   sel_d = ~sel_q;
    if (pop && !head_is_end) begin
      valid_d = 1'b1;
      data_d  = head_data;
    end else if (instr_ack) begin
      valid_d = 1'b0;
    end
    if (end_seq && (!instr0_fifo_empty || !instr1_fifo_empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign instr_valid      = valid_q;
  assign instr_data       = data_q;
  assign seq_err          = err_q;
  assign dispatcher_ready = ready_q;

`ifdef ISEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts accepted words; saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (start_seq)
      cnt_d = '0;
    else if (valid_q && instr_ack && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign iseq_cnt = cnt_q;
`else
  assign iseq_cnt = '0;
`endif

endmodule

// File: tb/tb_iseq_fifo_reader.sv
// Randomized self-checking bench for iseq_fifo_reader with queue-based FWFT
// FIFO models and a sequence-level reference model.
module tb_iseq_fifo_reader;
  import iseq_fifo_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, process_iseq, ack;
  logic        e0, e1, rd0, rd1, ready, valid, seq_err;
  logic [31:0] d0, d1, idata;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  iseq_fifo_reader #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .process_iseq(process_iseq),
    .instr0_fifo_empty(e0), .instr1_fifo_empty(e1),
    .instr0_fifo_data(d0), .instr1_fifo_data(d1),
    .instr0_fifo_rd_en(rd0), .instr1_fifo_rd_en(rd1),
    .dispatcher_ready(ready), .instr_valid(valid), .instr_data(idata),
    .instr_ack(ack), .seq_err(seq_err), .iseq_cnt(cnt)
  );

  logic [31:0] q0[$], q1[$], got[$], expq[$];
  logic        exp_err;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == END_ISEQ) w[31:28] = 4'h1;
    return w;
  endfunction

  function automatic logic [31:0] end_word();
    logic [31:0] w;
    w = $urandom;
    w[31:28] = END_ISEQ;
    return w;
  endfunction

  // One clock cycle: present FIFO heads, check pop legality, advance FIFOs.
  task automatic cycle(input logic a, input logic p);
    logic r0, r1, stall, rst_now;
    logic [31:0] pd;
    ack = a; process_iseq = p;
    e0 = (q0.size() == 0); d0 = e0 ? 32'h0 : q0[0];
    e1 = (q1.size() == 0); d1 = e1 ? 32'h0 : q1[0];
    #1;
    checks++;
    if ((rd0 && rd1) || (rd0 && e0) || (rd1 && e1)) begin
      errors++;
      $display("FAIL rd_legal rd0=%b rd1=%b e0=%b e1=%b", rd0, rd1, e0, e1);
    end
    if (valid && !a && rst) begin
      checks++;
      if (rd0 || rd1) begin
        errors++;
        $display("FAIL stall_pop rd0=%b rd1=%b while output stalled", rd0, rd1);
      end
    end
    if (valid && a && rst) got.push_back(idata);
    r0 = rd0; r1 = rd1; stall = valid && !a; pd = idata; rst_now = rst;
    @(posedge clk);
    if (r0 && q0.size() > 0) void'(q0.pop_front());
    if (r1 && q1.size() > 0) void'(q1.pop_front());
    #1;
    if (stall && rst_now) begin
      checks++;
      if (valid !== 1'b1 || idata !== pd) begin
        errors++;
        $display("FAIL hold valid=%b data=%h expected valid=1 data=%h", valid, idata, pd);
      end
    end
  endtask

  // Reference: alternate F0,F1 from F0; stop on empty head or END word.
  task automatic model();
    logic [31:0] m0[$], m1[$], w;
    int s;
    m0 = q0; m1 = q1; expq.delete(); s = 0;
    forever begin
      if (s == 0 && m0.size() == 0) break;
      if (s == 1 && m1.size() == 0) break;
      w = (s == 0) ? m0.pop_front() : m1.pop_front();
      if (w[31:28] == END_ISEQ) break;
      expq.push_back(w);
      s = 1 - s;
    end
    exp_err = (m0.size() != 0) || (m1.size() != 0);
  endtask

  task automatic apply_reset();
    q0.delete(); q1.delete();
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
  endtask

  // mode 0: ack always 1; 1: random ack; 2: ack low for first 5 valid cycles.
  // reproc: pulse process_iseq randomly while busy.
  task automatic run_seq(input string nm, input int mode, input bit reproc, output int nvalid);
    int stall_left, n;
    logic a;
    bit done;
    model();
    got.delete(); nvalid = 0; stall_left = 5; done = 0;
    cycle($urandom_range(0, 1), 1'b1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_low ready=%b expected 0", nm, ready);
    end
    for (n = 0; n < 300; n++) begin
      if (ready === 1'b1) begin done = 1; break; end
      if (valid) nvalid++;
      case (mode)
        0: a = 1'b1;
        1: a = $urandom_range(0, 1);
        default: begin
          a = 1'b1;
          if (valid && stall_left > 0) begin a = 1'b0; stall_left--; end
        end
      endcase
      cycle(a, reproc ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout ready=%b expected 1 within 300 cycles", nm, ready);
    end
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_len got=%0d expected=%0d", nm, got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++;
          $display("FAIL %s_word%0d got=%h expected=%h", nm, i, got[i], expq[i]);
        end
      end
    end
    checks++;
    if (seq_err !== exp_err) begin
      errors++;
      $display("FAIL %s_seq_err got=%b expected=%b", nm, seq_err, exp_err);
    end
    checks++;
`ifdef ISEQ_CNT_EN
    if (cnt !== 16'(expq.size())) begin
      errors++;
      $display("FAIL %s_cnt got=%0d expected=%0d", nm, cnt, expq.size());
    end
`else
    if (cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s_cnt got=%0d expected=0", nm, cnt);
    end
`endif
  endtask

  task automatic test_reset();
    q0.delete(); q1.delete();
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || idata !== 32'h0 || ready !== 1'b0 || seq_err !== 1'b0 ||
        cnt !== 16'h0 || rd0 !== 1'b0 || rd1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%h ready=%b err=%b cnt=%0d rd=%b%b expected all 0",
               valid, idata, ready, seq_err, cnt, rd0, rd1);
    end
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b expected 1", ready);
    end
  endtask

  task automatic test_basic();
    int nv;
    apply_reset();
    q0 = {32'h1000_000A, 32'h3000_000C};
    q1 = {32'h2000_000B, end_word()};
    run_seq("basic", 0, 0, nv);
    checks++;
    if (nv != 3) begin
      errors++;
      $display("FAIL basic_valid_cycles got=%0d expected=3", nv);
    end
  endtask

  task automatic test_maint();
    int nv;
    apply_reset();
    q0 = {rand_word()};
    q1 = {rand_word()};
    run_seq("maint", 1, 0, nv);
  endtask

  task automatic test_backpressure();
    int nv;
    apply_reset();
    q0 = {rand_word(), rand_word(), rand_word()};
    q1 = {rand_word(), rand_word(), end_word()};
    run_seq("stall", 2, 0, nv);
  endtask

  task automatic test_reprocess();
    int nv;
    apply_reset();
    q0 = {rand_word(), rand_word(), rand_word()};
    q1 = {rand_word(), rand_word()};
    run_seq("reproc", 1, 1, nv);
  endtask

  task automatic test_seq_err();
    int nv;
    apply_reset();
    q0 = {rand_word(), end_word()};
    q1 = {rand_word(), rand_word()};
    run_seq("seqerr", 0, 0, nv);
  endtask

  task automatic test_reset_mid();
    int s0, s1, n;
    apply_reset();
    q0 = {rand_word(), rand_word(), rand_word()};
    q1 = {rand_word(), rand_word(), rand_word()};
    cycle(1'b0, 1'b1);
    for (n = 0; n < 20 && valid !== 1'b1; n++) cycle(1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup valid=%b expected 1", valid);
    end
    s0 = q0.size(); s1 = q1.size();
    rst = 1'b0;
    cycle(1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0 || ready !== 1'b0 || q0.size() != s0 || q1.size() != s1) begin
      errors++;
      $display("FAIL midrst_abort valid=%b ready=%b sizes=%0d,%0d expected 0,0,%0d,%0d",
               valid, ready, q0.size(), q1.size(), s0, s1);
    end
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release ready=%b valid=%b expected 1,0", ready, valid);
    end
  endtask

  task automatic test_random();
    int nv, n0, n1;
    for (int it = 0; it < 20; it++) begin
      apply_reset();
      n0 = $urandom_range(0, 6); n1 = $urandom_range(0, 6);
      for (int k = 0; k < n0; k++) q0.push_back(rand_word());
      for (int k = 0; k < n1; k++) q1.push_back(rand_word());
      if (n0 > 0 && $urandom_range(0, 1)) q0[$urandom_range(0, n0 - 1)] = end_word();
      if (n1 > 0 && $urandom_range(0, 3) == 0) q1[$urandom_range(0, n1 - 1)] = end_word();
      run_seq("rand", 1, $urandom_range(0, 1), nv);
    end
  endtask

  initial begin
    rst = 1'b0; process_iseq = 1'b0; ack = 1'b0;
    e0 = 1'b1; e1 = 1'b1; d0 = '0; d1 = '0;
    #2;
    test_reset();
    test_basic();
    test_maint();
    test_backpressure();
    test_reprocess();
    test_seq_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
